// File: rtl/bsg_popcount_select.sv
// bsg_popcount_select: find the bit position of the rank-th set bit in a vector.
// Scans chunk_p bits per cycle. A per-chunk popcount either locates the hit
// inside the current chunk or is subtracted from the remaining rank.
// Optional macro BSG_POPCOUNT_SELECT_BYPASS_EN evaluates chunk 0 directly from
// vec_i/rank_i in the accepting cycle, which saves one cycle of latency.
//
// state | meaning
// IDLE  | ready for a request
// SCAN  | examining chunk c_r, rem_r set bits still to skip
// DONE  | result held on idx_o/found_o until yumi_i
module bsg_popcount_select
  #(parameter int width_p = 32
  , parameter int chunk_p = 8
  , localparam int lg_w_lp = $clog2(width_p)
  )
  (input  logic               clk_i
  ,input  logic               reset_n_i
  ,input  logic               v_i
  ,output logic               ready_o
  ,input  logic [width_p-1:0] vec_i
  ,input  logic [lg_w_lp-1:0] rank_i
  ,output logic               v_o
  ,output logic [lg_w_lp-1:0] idx_o
  ,output logic               found_o
  ,input  logic               yumi_i
  );

  localparam int c_lp     = width_p / chunk_p;
  localparam int cw_lp    = (c_lp > 1) ? $clog2(c_lp) : 1;
  localparam int lg_c_lp  = (chunk_p > 1) ? $clog2(chunk_p) : 1;
  localparam int cnt_w_lp = $clog2(chunk_p) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e state_r, state_n;

  logic [width_p-1:0] vec_r;
  logic [lg_w_lp-1:0] rem_r;
  logic [cw_lp-1:0]   c_r;
  logic [lg_w_lp-1:0] idx_r;
  logic               found_r;

  logic [width_p-1:0]  ev_vec;
  logic [lg_w_lp-1:0]  ev_rem;
  logic [cw_lp-1:0]    ev_c;
  logic [chunk_p-1:0]  ev_chunk;
  logic [cnt_w_lp-1:0] ev_cnt;
  logic [lg_c_lp-1:0]  ev_pos;
  logic                ev_hit;
  logic                ev_last;
  logic [lg_w_lp-1:0]  ev_idx;
  logic [lg_w_lp-1:0]  ev_rem_next;
  logic [cw_lp-1:0]    ev_c_next;

  function automatic logic [cnt_w_lp-1:0] chunk_popcount(input logic [chunk_p-1:0] v);
    logic [cnt_w_lp-1:0] n;
    n = '0;
    for (int i = 0; i < chunk_p; i++) n = n + cnt_w_lp'(v[i]);
    return n;
  endfunction

  // Position of the r-th one within a chunk, counting from bit 0 upward.
  function automatic logic [lg_c_lp-1:0] chunk_select(input logic [chunk_p-1:0] v,
                                                      input logic [lg_w_lp-1:0] r);
    logic [lg_w_lp-1:0] seen;
    logic [lg_c_lp-1:0] pos;
    seen = '0;
    pos  = '0;
    for (int i = 0; i < chunk_p; i++) begin
      if (v[i]) begin
        if (seen == r) pos = lg_c_lp'(i);
        seen = seen + 1'b1;
      end
    end
    return pos;
  endfunction

  // Chunk evaluation: registered operands while scanning; in the bypass build
  // the incoming request feeds chunk 0 while idle.
  always_comb begin
    ev_vec = vec_r;
    ev_rem = rem_r;
    ev_c   = c_r;
`ifdef BSG_POPCOUNT_SELECT_BYPASS_EN
    if (state_r == IDLE) begin
      ev_vec = vec_i;
      ev_rem = rank_i;
      ev_c   = '0;
    end
`endif
    ev_chunk    = ev_vec[ev_c*chunk_p +: chunk_p];
    ev_cnt      = chunk_popcount(ev_chunk);
    ev_pos      = chunk_select(ev_chunk, ev_rem);
    ev_hit      = (32'(ev_rem) < 32'(ev_cnt));
    ev_last     = (ev_c == cw_lp'(c_lp - 1));
    ev_idx      = (lg_w_lp'(ev_c) << $clog2(chunk_p)) | lg_w_lp'(ev_pos);
    ev_rem_next = ev_rem - lg_w_lp'(ev_cnt);
    ev_c_next   = ev_c + 1'b1;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: if (v_i) begin
`ifdef BSG_POPCOUNT_SELECT_BYPASS_EN
        state_n = (ev_hit || ev_last) ? DONE : SCAN;
`else
        state_n = SCAN;
`endif
      end
      SCAN: if (ev_hit || ev_last) state_n = DONE;
      DONE: if (yumi_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs; both handshakes are held low while reset is asserted.
  always_comb begin
    ready_o = reset_n_i && (state_r == IDLE);
    v_o     = reset_n_i && (state_r == DONE);
    idx_o   = idx_r;
    found_o = found_r;
  end

  // Datapath: capture request, then skip or locate one chunk per cycle.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      vec_r   <= '0;
      rem_r   <= '0;
      c_r     <= '0;
      idx_r   <= '0;
      found_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: if (v_i) begin
          vec_r   <= vec_i;
          rem_r   <= rank_i;
          c_r     <= '0;
          idx_r   <= '0;
          found_r <= 1'b0;
`ifdef BSG_POPCOUNT_SELECT_BYPASS_EN
          if (ev_hit) begin
            idx_r   <= ev_idx;
            found_r <= 1'b1;
          end else if (!ev_last) begin
            rem_r <= ev_rem_next;
            c_r   <= ev_c_next;
          end
`endif
        end
        SCAN: begin
          if (ev_hit) begin
            idx_r   <= ev_idx;
            found_r <= 1'b1;
          end else if (ev_last) begin
            idx_r   <= '0;
            found_r <= 1'b0;
          end else begin
            rem_r <= ev_rem_next;
            c_r   <= ev_c_next;
          end
        end
        default: ;
      endcase
    end
  end

  // A consumer may only take a result that is being offered.
  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_popcount_select.sv
// Directed bench for bsg_popcount_select with a small reference model and an
// expected-result queue popped when the engine presents each result.
module tb_bsg_popcount_select;

  localparam int W = 32;
  localparam int K = 8;
  localparam int C = W / K;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic         v_i;
  logic         ready_o;
  logic [W-1:0] vec_i;
  logic [4:0]   rank_i;
  logic         v_o;
  logic [4:0]   idx_o;
  logic         found_o;
  logic         yumi_i;

  typedef struct {
    logic [4:0] idx;
    logic       found;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;

  bsg_popcount_select #(.width_p(W), .chunk_p(K)) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .vec_i    (vec_i),
    .rank_i   (rank_i),
    .v_o      (v_o),
    .idx_o    (idx_o),
    .found_o  (found_o),
    .yumi_i   (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Bit-serial reference: walk the vector from bit 0, counting set bits.
  function automatic exp_t model(input logic [W-1:0] v, input logic [4:0] r);
    exp_t e;
    int seen;
    e.idx = '0;
    e.found = 1'b0;
    seen = 0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) begin
        if (seen == int'(r) && !e.found) begin
          e.idx = 5'(i);
          e.found = 1'b1;
        end
        seen++;
      end
    end
`ifdef BSG_POPCOUNT_SELECT_BYPASS_EN
    e.lat = e.found ? int'(e.idx) / K : C - 1;
`else
    e.lat = e.found ? int'(e.idx) / K + 1 : C;
`endif
    return e;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one request, optionally poke v_i while busy, hold the result, consume it.
  task automatic send(input logic [W-1:0] v, input logic [4:0] r,
                      input int hold, input bit poke, input string tag);
    exp_t e;
    int lat;
    int guard;
    guard = 0;
    while (!ready_o && guard < 50) begin step(); guard++; end
    chk({tag, "_ready"}, 32'(ready_o), 32'd1);
    sb.push_back(model(v, r));
    v_i = 1'b1; vec_i = v; rank_i = r;
    step();
    v_i = 1'b0;
    if (poke) begin
      v_i = 1'b1; vec_i = 32'hFFFF_FFFF; rank_i = 5'd0;
    end
    lat = 0;
    while (!v_o && lat < 50) begin step(); lat++; end
    v_i = 1'b0;
    e = sb.pop_front();
    chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    chk({tag, "_idx"}, 32'(idx_o), 32'(e.idx));
    chk({tag, "_found"}, 32'(found_o), 32'(e.found));
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_v"}, 32'(v_o), 32'd1);
      chk({tag, "_hold_idx"}, 32'(idx_o), 32'(e.idx));
    end
    yumi_i = 1'b1;
    v_i = poke;
    step();
    yumi_i = 1'b0;
    v_i = 1'b0;
    chk({tag, "_post_v"}, 32'(v_o), 32'd0);
    chk({tag, "_post_ready"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    reset_n_i = 1'b0; v_i = 1'b0; vec_i = '0; rank_i = '0; yumi_i = 1'b0;
    #1;
    step(); step();
    chk("rst_v", 32'(v_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_idx", 32'(idx_o), 32'd0);
    chk("rst_found", 32'(found_o), 32'd0);
    reset_n_i = 1'b1;
    step();
    chk("rel_ready", 32'(ready_o), 32'd1);

    send(32'h0000_0001, 5'd0,  0, 1'b0, "lsb");
    send(32'h8000_0000, 5'd0,  0, 1'b0, "msb");
    send(32'hA5A5_A5A5, 5'd9,  5, 1'b0, "a5");
    send(32'h0000_00F0, 5'd4,  0, 1'b0, "miss");
    send(32'h0000_0000, 5'd0,  0, 1'b0, "zero");
    send(32'hFFFF_FFFF, 5'd31, 0, 1'b1, "ones31");
    send(32'hFFFF_FFFF, 5'd17, 0, 1'b1, "ones17");
    send(32'h0100_0000, 5'd0,  1, 1'b0, "chunk3");
    for (int n = 0; n < 6; n++) begin
      logic [W-1:0] rv;
      rv = $urandom() & $urandom();
      send(rv, 5'($urandom_range(0, 15)), 0, n[0], "rand");
    end

    // Reset during SCAN discards the request.
    v_i = 1'b1; vec_i = 32'h8000_0000; rank_i = 5'd0;
    step();
    v_i = 1'b0;
    step();
    reset_n_i = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready_o), 32'd0);
    chk("midrst_v", 32'(v_o), 32'd0);
    step();
    step();
    chk("midrst_v2", 32'(v_o), 32'd0);
    reset_n_i = 1'b1;
    step();
    chk("midrst_rel_ready", 32'(ready_o), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_no_stale", 32'(v_o), 32'd0);
    end
    send(32'h0000_0400, 5'd0, 0, 1'b0, "after_rst");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
